// File: rtl/env_step_ctrl_if.sv
// Agent and Compute handshake/bus bundle for env_step_ctrl.
// The slave modport is the controller's view; master is the agent/Compute side.
interface env_step_ctrl_if #(
  parameter int PE_NUM = 20,
  parameter int STA_WL = 128,
  parameter int ACT_WL = 1,
  parameter int RWD_WL = 1
);
  logic                       i_act_valid;
  logic                       o_act_ready;
  logic [PE_NUM*ACT_WL-1:0]   i_act;
  logic                       o_obs_valid;
  logic                       i_obs_ready;
  logic [PE_NUM*STA_WL-1:0]   o_sta;
  logic [PE_NUM*RWD_WL-1:0]   o_rwd;
  logic [PE_NUM-1:0]          o_done;
  logic [PE_NUM-1:0]          o_trunc;
  logic                       o_cmpt_ena;
  logic [PE_NUM*STA_WL-1:0]   o_cmpt_sta;
  logic [PE_NUM*ACT_WL-1:0]   o_cmpt_act;
  logic [PE_NUM*STA_WL-1:0]   i_cmpt_sta;
  logic [PE_NUM*RWD_WL-1:0]   i_cmpt_rwd;
  logic [PE_NUM-1:0]          i_cmpt_done;
  logic                       i_cmpt_valid;

  modport slave (
    input  i_act_valid, i_act, i_obs_ready, i_cmpt_sta, i_cmpt_rwd, i_cmpt_done, i_cmpt_valid,
    output o_act_ready, o_obs_valid, o_sta, o_rwd, o_done, o_trunc, o_cmpt_ena, o_cmpt_sta, o_cmpt_act
  );

  modport master (
    output i_act_valid, i_act, i_obs_ready, i_cmpt_sta, i_cmpt_rwd, i_cmpt_done, i_cmpt_valid,
    input  o_act_ready, o_obs_valid, o_sta, o_rwd, o_done, o_trunc, o_cmpt_ena, o_cmpt_sta, o_cmpt_act
  );
endinterface

// File: rtl/env_step_ctrl.sv
// Cartpole env controller: owns per-env state, steps Compute, auto-resets done envs from an LFSR (4*PE_NUM-cycle scan).
// Result held on o_obs_* until i_obs_ready; no action accepted meanwhile. ENV_STATS_EN adds o_ep_cnt/o_step_cnt.
module env_step_ctrl #(
  parameter int          PE_NUM    = 20,
  parameter int          STA_WL    = 128,
  parameter int          ACT_WL    = 1,
  parameter int          RWD_WL    = 1,
  parameter int          MAX_STEPS = 500,
  parameter int          CNT_WL    = 9,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  env_step_ctrl_if.slave   bus
`ifdef ENV_STATS_EN
  ,
  output logic [31:0]      o_ep_cnt,
  output logic [31:0]      o_step_cnt
`endif
);
  localparam int          SCAN_LEN  = 4 * PE_NUM;
  localparam int          SCAN_WL   = $clog2(SCAN_LEN);
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [2:0] {S_INIT, S_WAIT_ACT, S_COMPUTE, S_OUTPUT, S_REFILL} state_t;
  state_t state_q, state_d;

  logic [SCAN_WL-1:0] scan_k;
  logic               scan_on, scan_last;
  logic [31:0]        lfsr_q, lfsr_nxt, rand_word;
  logic [STA_WL-1:0]  sta_q   [PE_NUM];
  logic [CNT_WL-1:0]  cnt_q   [PE_NUM];
  logic [CNT_WL-1:0]  cnt_inc [PE_NUM];
  logic [PE_NUM-1:0]  pend_q, done_nxt, trunc_nxt;
  logic               act_hs, cmpt_cap, obs_hs;

  assign scan_on   = (state_q == S_INIT) || (state_q == S_REFILL);
  assign scan_last = (scan_k == SCAN_WL'(SCAN_LEN - 1));
  assign act_hs    = (state_q == S_WAIT_ACT) && bus.i_act_valid;
  assign cmpt_cap  = (state_q == S_COMPUTE) && bus.i_cmpt_valid;
  assign obs_hs    = (state_q == S_OUTPUT) && bus.i_obs_ready;

  assign lfsr_nxt  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  assign rand_word = {lfsr_q[31], 8'd122, lfsr_q[22:0]};

  assign bus.o_act_ready = (state_q == S_WAIT_ACT);
  assign bus.o_obs_valid = (state_q == S_OUTPUT);
  assign bus.o_cmpt_ena  = (state_q == S_COMPUTE);

  always_comb begin
    bus.o_cmpt_sta = '0;
    done_nxt       = '0;
    trunc_nxt      = '0;
    for (int g = 0; g < PE_NUM; g++) begin
      bus.o_cmpt_sta[g*STA_WL +: STA_WL] = sta_q[g];
      cnt_inc[g]   = cnt_q[g] + CNT_WL'(1);
      done_nxt[g]  = bus.i_cmpt_done[g] | (cnt_inc[g] == CNT_WL'(MAX_STEPS));
      trunc_nxt[g] = (cnt_inc[g] == CNT_WL'(MAX_STEPS)) & ~bus.i_cmpt_done[g];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:     if (scan_last) state_d = S_WAIT_ACT;
      S_WAIT_ACT: if (act_hs)    state_d = S_COMPUTE;
      S_COMPUTE:  if (cmpt_cap)  state_d = S_OUTPUT;
      S_OUTPUT:   if (obs_hs)    state_d = (|pend_q) ? S_REFILL : S_WAIT_ACT;
      S_REFILL:   if (scan_last) state_d = S_WAIT_ACT;
      default:                   state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      scan_k         <= '0;
      lfsr_q         <= LFSR_SEED;
      pend_q         <= '0;
      bus.o_cmpt_act <= '0;
      bus.o_sta      <= '0;
      bus.o_rwd      <= '0;
      bus.o_done     <= '0;
      bus.o_trunc    <= '0;
      for (int g = 0; g < PE_NUM; g++) begin
        sta_q[g] <= '0;
        cnt_q[g] <= '0;
      end
    end else begin
      // The LFSR steps on every scan cycle, written or not, so refill values depend only on history.
      if (scan_on) begin
        lfsr_q <= lfsr_nxt;
        scan_k <= scan_last ? '0 : scan_k + SCAN_WL'(1);
        for (int g = 0; g < PE_NUM; g++) begin
          if ((int'(scan_k[SCAN_WL-1:2]) == g) && ((state_q == S_INIT) || pend_q[g]))
            sta_q[g][{~scan_k[1:0], 5'd0} +: 32] <= rand_word;
        end
      end
      if ((state_q == S_REFILL) && scan_last) pend_q <= '0;
      if (act_hs) bus.o_cmpt_act <= bus.i_act;
      if (cmpt_cap) begin
        pend_q      <= done_nxt;
        bus.o_done  <= done_nxt;
        bus.o_trunc <= trunc_nxt;
        for (int g = 0; g < PE_NUM; g++) begin
          bus.o_sta[g*STA_WL +: STA_WL] <= bus.i_cmpt_sta[g*STA_WL +: STA_WL];
          bus.o_rwd[g*RWD_WL +: RWD_WL] <= bus.i_cmpt_rwd[g*RWD_WL +: RWD_WL];
          sta_q[g] <= bus.i_cmpt_sta[g*STA_WL +: STA_WL];
          cnt_q[g] <= done_nxt[g] ? '0 : cnt_inc[g];
        end
      end
    end
  end

`ifdef ENV_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_ep_cnt   <= '0;
      o_step_cnt <= '0;
    end else begin
      if (act_hs)   o_step_cnt <= o_step_cnt + 32'd1;
      if (cmpt_cap) o_ep_cnt   <= o_ep_cnt + 32'($countones(done_nxt));
    end
  end
`endif

endmodule

// File: tb/tb_env_step_ctrl.sv
// Scoreboarded bench for env_step_ctrl with PE_NUM=2, MAX_STEPS=3.
// Directed steps push expected results; a negedge monitor pops them on each observation handshake.
module tb_env_step_ctrl;
  localparam int          PE   = 2;
  localparam int          SW   = 128;
  localparam int          MAXS = 3;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  env_step_ctrl_if #(.PE_NUM(PE), .STA_WL(SW), .ACT_WL(1), .RWD_WL(1)) bus();

`ifdef ENV_STATS_EN
  logic [31:0] ep_cnt, step_cnt;
`endif

  env_step_ctrl #(
    .PE_NUM(PE), .STA_WL(SW), .ACT_WL(1), .RWD_WL(1),
    .MAX_STEPS(MAXS), .CNT_WL(2), .LFSR_SEED(SEED)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
`ifdef ENV_STATS_EN
    ,
    .o_ep_cnt  (ep_cnt),
    .o_step_cnt(step_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [PE*SW-1:0] sta;
    logic [PE-1:0]    rwd;
    logic [PE-1:0]    done;
    logic [PE-1:0]    trunc;
  } obs_t;
  obs_t sb[$];

  logic [31:0]    m_lfsr;
  logic [SW-1:0]  m_sta [PE];
  int             m_cnt [PE];
  logic [PE-1:0]  m_pend;
  logic [PE*SW-1:0] first_init;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PE*SW-1:0] m_cmpt_sta();
    return {m_sta[1], m_sta[0]};
  endfunction

  function automatic logic [PE*SW-1:0] pat(input logic [31:0] s);
    return {{4{s ^ 32'hFFFF0000}}, {4{s}}};
  endfunction

  task automatic m_reset();
    m_lfsr = SEED;
    m_pend = '0;
    for (int g = 0; g < PE; g++) begin
      m_sta[g] = '0;
      m_cnt[g] = 0;
    end
  endtask

  task automatic m_scan(input logic [PE-1:0] sel);
    for (int k = 0; k < 4*PE; k++) begin
      if (sel[k/4]) m_sta[k/4][(3-(k%4))*32 +: 32] = {m_lfsr[31], 8'd122, m_lfsr[22:0]};
      m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
    end
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.o_act_ready) break;
    end
    chk(name, n, exp_cycles);
  endtask

  // Caller sits at #1 after an edge with the DUT in WAIT_ACT.
  task automatic do_step(input logic [PE-1:0] act, input logic [PE-1:0] cdone,
                         input logic [PE*SW-1:0] csta, input logic [PE-1:0] crwd,
                         input int dly, input int hold);
    obs_t e;
    int ena_n = 0;
    chk("act_ready_before", bus.o_act_ready, 1);
    bus.i_act_valid = 1'b1;
    bus.i_act       = act;
    @(posedge clk); #1;
    bus.i_act_valid = 1'b0;
    bus.i_act       = ~act;
    chk("cmpt_act", bus.o_cmpt_act, act);
    for (int i = 0; i < dly; i++) begin
      if (bus.o_cmpt_ena) ena_n++;
      if (i == 0) chk("cmpt_sta_in_compute", bus.o_cmpt_sta, m_cmpt_sta());
      if (i == dly - 1) begin
        bus.i_cmpt_valid = 1'b1;
        bus.i_cmpt_sta   = csta;
        bus.i_cmpt_rwd   = crwd;
        bus.i_cmpt_done  = cdone;
      end
      @(posedge clk); #1;
    end
    bus.i_cmpt_valid = 1'b0;
    chk("ena_cycles", ena_n, dly);
    chk("ena_drop", bus.o_cmpt_ena, 0);
    chk("obs_valid_up", bus.o_obs_valid, 1);

    e.sta = csta;
    e.rwd = crwd;
    for (int g = 0; g < PE; g++) begin
      int  c;
      logic hit;
      c   = m_cnt[g] + 1;
      hit = (c == MAXS);
      e.done[g]  = cdone[g] | hit;
      e.trunc[g] = hit & ~cdone[g];
      m_cnt[g]   = e.done[g] ? 0 : c;
      m_pend[g]  = e.done[g];
      m_sta[g]   = csta[g*SW +: SW];
    end
    sb.push_back(e);

    for (int h = 0; h < hold; h++) begin
      bus.i_act_valid = 1'b1;
      chk("hold_obs_valid", bus.o_obs_valid, 1);
      chk("hold_act_ready", bus.o_act_ready, 0);
      chk("hold_sta", bus.o_sta, csta);
      @(posedge clk); #1;
    end
    bus.i_act_valid = 1'b0;
    if (hold > 0) chk("hold_no_new_act", bus.o_cmpt_act, act);

    bus.i_obs_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_obs_ready = 1'b0;
    chk("obs_valid_drop", bus.o_obs_valid, 0);
    if (|m_pend) begin
      chk("refill_not_ready", bus.o_act_ready, 0);
      m_scan(m_pend);
      m_pend = '0;
      wait_ready("refill_len", 8);
    end else begin
      chk("wait_act_1cyc", bus.o_act_ready, 1);
    end
    chk("cmpt_sta_after", bus.o_cmpt_sta, m_cmpt_sta());
    chk("sta_final_held", bus.o_sta, csta);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_obs_valid && bus.i_obs_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL obs_unexpected: result presented with no expected entry");
        end else begin
          obs_t e;
          e = sb.pop_front();
          chk("obs_sta", bus.o_sta, e.sta);
          chk("obs_rwd", bus.o_rwd, e.rwd);
          chk("obs_done", bus.o_done, e.done);
          chk("obs_trunc", bus.o_trunc, e.trunc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_act_valid  = 1'b0;
    bus.i_act        = '0;
    bus.i_obs_ready  = 1'b0;
    bus.i_cmpt_sta   = '0;
    bus.i_cmpt_rwd   = '0;
    bus.i_cmpt_done  = '0;
    bus.i_cmpt_valid = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_act_ready", bus.o_act_ready, 0);
    chk("rst_obs_valid", bus.o_obs_valid, 0);
    chk("rst_cmpt_ena", bus.o_cmpt_ena, 0);
    chk("rst_cmpt_sta", bus.o_cmpt_sta, 0);
    chk("rst_cmpt_act", bus.o_cmpt_act, 0);
    chk("rst_sta", bus.o_sta, 0);
    chk("rst_flags", {bus.o_done, bus.o_trunc, bus.o_rwd}, 0);

    rstn = 1'b1;
    m_reset();
    m_scan(2'b11);
    wait_ready("init_len", 8);
    chk("init_cmpt_sta", bus.o_cmpt_sta, m_cmpt_sta());
    chk("init_env0_x", bus.o_cmpt_sta[127:96], 32'hBD612468);
    first_init = bus.o_cmpt_sta;

    do_step(2'b10, 2'b01, pat(32'h11), 2'b10, 3, 0);
    do_step(2'b01, 2'b00, pat(32'h22), 2'b11, 2, 5);
    do_step(2'b11, 2'b00, pat(32'h33), 2'b01, 1, 0);

    // Reset with a step in flight; a late Compute result must be ignored.
    bus.i_act_valid = 1'b1;
    bus.i_act       = 2'b11;
    @(posedge clk); #1;
    bus.i_act_valid = 1'b0;
    chk("mid_compute_ena", bus.o_cmpt_ena, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ena", bus.o_cmpt_ena, 0);
    chk("mid_rst_cmpt_sta", bus.o_cmpt_sta, 0);
    chk("mid_rst_done", bus.o_done, 0);
    bus.i_cmpt_valid = 1'b1;
    bus.i_cmpt_done  = 2'b11;
    bus.i_cmpt_sta   = pat(32'hDEAD);
    rstn = 1'b1;
    m_reset();
    m_scan(2'b11);
    wait_ready("reinit_len", 8);
    bus.i_cmpt_valid = 1'b0;
    chk("reinit_no_obs", bus.o_obs_valid, 0);
    chk("reinit_sta_clear", bus.o_sta, 0);
    chk("reinit_same_as_first", bus.o_cmpt_sta, first_init);
    chk("reinit_model", bus.o_cmpt_sta, m_cmpt_sta());

    do_step(2'b00, 2'b00, pat(32'h44), 2'b00, 2, 0);
    do_step(2'b01, 2'b00, pat(32'h55), 2'b01, 2, 0);
    do_step(2'b10, 2'b00, pat(32'h66), 2'b10, 2, 0);
    do_step(2'b11, 2'b00, pat(32'h77), 2'b11, 2, 0);

    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    m_reset();
    m_scan(2'b11);
    wait_ready("stats_init_len", 8);
    for (int s = 0; s < 4; s++) do_step(2'(s), 2'b11, pat(32'h100 + s), 2'(s + 1), 1, 0);
`ifdef ENV_STATS_EN
    chk("ep_cnt", ep_cnt, 8);
    chk("step_cnt", step_cnt, 4);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
